// File: rtl/merge_select_control_pkg.sv
// Shared types and constants for the bitonic merger select controller.
package merge_select_control_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MERGE  = 2'd1,
        ST_TERM_B = 2'd2
    } state_t;

    localparam int unsigned          KEY_WIDTH = 32;
    localparam logic [KEY_WIDTH-1:0] KEY_TERM  = '0;

endpackage

// File: rtl/merge_select_control_run_stats.sv
// Run statistics: wrapping run counter, saturating element counter, done pulse.
module run_stats_counter #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_elem_inc,
    input  logic                   i_run_complete,
    output logic                   o_run_done,
    output logic [COUNT_WIDTH-1:0] o_run_count,
    output logic [COUNT_WIDTH-1:0] o_elem_count
);

    logic                   r_run_done;
    logic [COUNT_WIDTH-1:0] r_run_count;
    logic [COUNT_WIDTH-1:0] r_elem_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_run_done   <= 1'b0;
            r_run_count  <= '0;
            r_elem_count <= '0;
        end else begin
            r_run_done <= i_run_complete;
            if (i_run_complete) begin
                r_run_count  <= r_run_count + 1'b1;
                r_elem_count <= '0;
            end else if (i_elem_inc && (r_elem_count != '1)) begin
                r_elem_count <= r_elem_count + 1'b1;
            end
        end
    end

    assign o_run_done   = r_run_done;
    assign o_run_count  = r_run_count;
    assign o_elem_count = r_elem_count;

endmodule

// File: rtl/merge_select_control.sv
// Select/stall/terminator sequencing for the two-input bitonic merger.
module merge_select_control
    import merge_select_control_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic                   i_fifo_out_full,
    input  logic                   i_a_empty,
    input  logic                   i_b_empty,
    input  logic                   i_a_min_zero,
    input  logic                   i_b_min_zero,
    input  logic                   i_a_lte_b,
    output logic                   o_select_A,
    output logic                   o_stall,
    output logic                   o_switch_output,
    output logic                   o_drop,
    output logic                   o_run_done,
    output logic [COUNT_WIDTH-1:0] o_run_count,
    output logic [COUNT_WIDTH-1:0] o_elem_count
);

    state_t r_state;
    logic   r_last_sel;
    logic   w_select_A;
    logic   w_stall;
    logic   w_drop;
    logic   w_commit;
    logic   w_both_zero;

    assign w_both_zero = i_a_min_zero & i_b_min_zero;

    // Key 0 acts as +inf: a stream at its terminator yields to the other.
    always_comb begin
        w_select_A = 1'b1;
        w_stall    = 1'b1;
        w_drop     = 1'b0;
        if (i_rst_n) begin
            case (r_state)
                ST_MERGE: begin
                    w_stall = i_fifo_out_full | i_a_empty | i_b_empty;
                    if (w_both_zero)       w_select_A = 1'b1;
                    else if (i_a_min_zero) w_select_A = 1'b0;
                    else if (i_b_min_zero) w_select_A = 1'b1;
                    else                   w_select_A = i_a_lte_b;
                end
                ST_TERM_B: begin
                    w_stall    = i_fifo_out_full | i_b_empty;
                    w_select_A = 1'b0;
                    w_drop     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_commit = ~w_stall;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_last_sel <= 1'b1;
        end else begin
            if (w_commit) r_last_sel <= w_select_A;
            case (r_state)
                ST_IDLE:   if (i_enable) r_state <= ST_MERGE;
                ST_MERGE:  if (w_commit && w_both_zero) r_state <= ST_TERM_B;
                ST_TERM_B: if (w_commit) r_state <= i_enable ? ST_MERGE : ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    run_stats_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_stats (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_elem_inc     (w_commit && (r_state == ST_MERGE)),
        .i_run_complete (w_commit && (r_state == ST_TERM_B)),
        .o_run_done     (o_run_done),
        .o_run_count    (o_run_count),
        .o_elem_count   (o_elem_count)
    );

    assign o_select_A      = w_select_A;
    assign o_stall         = w_stall;
    assign o_drop          = w_drop;
    assign o_switch_output = i_rst_n & (w_select_A ^ r_last_sel);

endmodule

// File: tb/tb_merge_select_control.sv
// Directed bench for merge_select_control: vector table plus FIFO-driven run sequences.
module tb_merge_select_control;

    localparam int unsigned CW = 3;

    logic          i_clk = 1'b0;
    logic          i_rst_n, i_enable, i_fifo_out_full;
    logic          i_a_empty, i_b_empty, i_a_min_zero, i_b_min_zero, i_a_lte_b;
    logic          o_select_A, o_stall, o_switch_output, o_drop, o_run_done;
    logic [CW-1:0] o_run_count, o_elem_count;

    merge_select_control #(.COUNT_WIDTH(CW)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_enable        (i_enable),
        .i_fifo_out_full (i_fifo_out_full),
        .i_a_empty       (i_a_empty),
        .i_b_empty       (i_b_empty),
        .i_a_min_zero    (i_a_min_zero),
        .i_b_min_zero    (i_b_min_zero),
        .i_a_lte_b       (i_a_lte_b),
        .o_select_A      (o_select_A),
        .o_stall         (o_stall),
        .o_switch_output (o_switch_output),
        .o_drop          (o_drop),
        .o_run_done      (o_run_done),
        .o_run_count     (o_run_count),
        .o_elem_count    (o_elem_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic full, ae, be, az, bz, lte;
        logic sel, stall, drop, sw;
    } vec_t;

    typedef struct packed {
        logic        sw;
        logic        drop;
        logic        src;
        logic [31:0] key;
    } commit_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    commit_t     log_q[$];
    logic [CW-1:0] elem_at_drop[$];
    logic        frc_a_empty = 1'b0;
    logic        frc_b_empty = 1'b0;
    logic        s_stall, s_sel, s_drop, s_sw;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic commit_t mk(input logic [31:0] key, input logic src,
                                   input logic drop, input logic sw);
        commit_t c;
        c.key = key; c.src = src; c.drop = drop; c.sw = sw;
        return c;
    endfunction

    task automatic drive_heads();
        i_a_empty    = (qa.size() == 0) || frc_a_empty;
        i_b_empty    = (qb.size() == 0) || frc_b_empty;
        i_a_min_zero = (qa.size() != 0) ? (qa[0] == 32'd0) : 1'b0;
        i_b_min_zero = (qb.size() != 0) ? (qb[0] == 32'd0) : 1'b0;
        i_a_lte_b    = (qa.size() != 0 && qb.size() != 0) ? (qa[0] <= qb[0]) : 1'b0;
    endtask

    // One clock: present FIFO heads, sample outputs, pop on commit, check done pulse.
    task automatic step();
        commit_t c;
        logic    drop_commit;
        drive_heads();
        #1;
        s_stall = o_stall; s_sel = o_select_A; s_drop = o_drop; s_sw = o_switch_output;
        drop_commit = 1'b0;
        if (!o_stall) begin
            c.sw = o_switch_output; c.drop = o_drop; c.src = o_select_A;
            if (o_select_A) c.key = (qa.size() != 0) ? qa[0] : 32'hDEAD_BEEF;
            else            c.key = (qb.size() != 0) ? qb[0] : 32'hDEAD_BEEF;
            log_q.push_back(c);
            if (o_drop) begin
                elem_at_drop.push_back(o_elem_count);
                drop_commit = 1'b1;
            end
            if (o_select_A && qa.size() != 0) void'(qa.pop_front());
            if (!o_select_A && qb.size() != 0) void'(qb.pop_front());
        end
        @(posedge i_clk); #1;
        chk("run_done_pulse", o_run_done, drop_commit);
    endtask

    vec_t          vt[9];
    commit_t       exp_log[28];
    logic [CW-1:0] exp_elem[5];

    initial begin
        // full ae be az bz lte | sel stall drop sw (last_sel = 1)
        vt[0] = '{0,0,0,0,0,1, 1,0,0,0};
        vt[1] = '{0,0,0,0,0,0, 0,0,0,1};
        vt[2] = '{0,0,0,1,0,1, 0,0,0,1};
        vt[3] = '{0,0,0,0,1,0, 1,0,0,0};
        vt[4] = '{0,0,0,1,1,0, 1,0,0,0};
        vt[5] = '{1,0,0,0,0,0, 0,1,0,1};
        vt[6] = '{0,1,0,0,0,1, 1,1,0,0};
        vt[7] = '{0,0,1,0,0,0, 0,1,0,1};
        vt[8] = '{0,1,1,0,0,1, 1,1,0,0};

        exp_log[0]  = mk(1, 1, 0, 0);  exp_log[1]  = mk(2, 0, 0, 1);
        exp_log[2]  = mk(3, 0, 0, 0);  exp_log[3]  = mk(4, 1, 0, 1);
        exp_log[4]  = mk(0, 1, 0, 0);  exp_log[5]  = mk(0, 0, 1, 1);
        exp_log[6]  = mk(5, 0, 0, 0);  exp_log[7]  = mk(6, 0, 0, 0);
        exp_log[8]  = mk(0, 1, 0, 1);  exp_log[9]  = mk(0, 0, 1, 1);
        exp_log[10] = mk(7, 1, 0, 1);  exp_log[11] = mk(8, 0, 0, 1);
        exp_log[12] = mk(0, 1, 0, 1);  exp_log[13] = mk(0, 0, 1, 1);
        exp_log[14] = mk(9, 1, 0, 1);  exp_log[15] = mk(10, 0, 0, 1);
        exp_log[16] = mk(0, 1, 0, 0);  exp_log[17] = mk(0, 0, 1, 1);
        exp_log[18] = mk(1, 1, 0, 1);
        for (int k = 2; k <= 8; k++) exp_log[17 + k] = mk(k, 1, 0, 0);
        exp_log[26] = mk(0, 1, 0, 0);  exp_log[27] = mk(0, 0, 1, 1);
        exp_elem = '{3'd5, 3'd3, 3'd3, 3'd1, 3'd7};

        i_rst_n = 1'b0; i_enable = 1'b0; i_fifo_out_full = 1'b0;
        i_a_empty = 1'b1; i_b_empty = 1'b1;
        i_a_min_zero = 1'b0; i_b_min_zero = 1'b0; i_a_lte_b = 1'b0;

        // Reset: outputs forced while low, registers cleared after release
        @(posedge i_clk); #1;
        i_a_empty = 1'b0; i_b_empty = 1'b0; i_a_lte_b = 1'b0;
        #1;
        chk("rst_stall", o_stall, 1'b1);
        chk("rst_sel", o_select_A, 1'b1);
        chk("rst_drop", o_drop, 1'b0);
        chk("rst_switch", o_switch_output, 1'b0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        #1;
        chk("idle_stall", o_stall, 1'b1);
        chk("idle_sel", o_select_A, 1'b1);
        chk("rst_run_count", o_run_count, 0);
        chk("rst_elem_count", o_elem_count, 0);
        chk("rst_run_done", o_run_done, 1'b0);

        i_fifo_out_full = 1'b1;
        i_enable = 1'b1;
        @(posedge i_clk); #1;

        // Combinational selection in MERGE; parked with full=1 before each edge
        for (int i = 0; i < 9; i++) begin
            i_fifo_out_full = vt[i].full; i_a_empty = vt[i].ae; i_b_empty = vt[i].be;
            i_a_min_zero = vt[i].az; i_b_min_zero = vt[i].bz; i_a_lte_b = vt[i].lte;
            #1;
            chk($sformatf("vec%0d_sel", i), o_select_A, vt[i].sel);
            chk($sformatf("vec%0d_stall", i), o_stall, vt[i].stall);
            chk($sformatf("vec%0d_drop", i), o_drop, vt[i].drop);
            chk($sformatf("vec%0d_switch", i), o_switch_output, vt[i].sw);
            i_fifo_out_full = 1'b1;
            @(posedge i_clk); #1;
        end
        i_fifo_out_full = 1'b0;

        // Basic merge followed back-to-back by asymmetric run: no bubbles
        qa = '{1, 4, 0, 0};
        qb = '{2, 3, 0, 5, 6, 0};
        for (int i = 0; i < 10; i++) step();
        chk("no_bubble_commits", log_q.size(), 10);
        chk("run_count_2", o_run_count, 2);
        chk("elem_cleared", o_elem_count, 0);

        // Backpressure, empty heads, pause
        qa = '{7, 0};
        qb = '{8, 0};
        step();
        i_enable = 1'b0;
        i_fifo_out_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_stall", s_stall, 1'b1);
            chk("bp_sel", s_sel, 1'b0);
            chk("bp_elem_hold", o_elem_count, 1);
        end
        chk("bp_no_commit", log_q.size(), 11);
        i_fifo_out_full = 1'b0;
        frc_b_empty = 1'b1;
        step();
        chk("merge_b_empty_stall", s_stall, 1'b1);
        frc_b_empty = 1'b0;
        step();
        step();
        frc_b_empty = 1'b1;
        step();
        chk("termb_b_empty_stall", s_stall, 1'b1);
        chk("termb_drop", s_drop, 1'b1);
        frc_b_empty = 1'b0;
        frc_a_empty = 1'b1;
        step();
        chk("termb_a_empty_commit", s_stall, 1'b0);
        frc_a_empty = 1'b0;
        chk("run_count_3", o_run_count, 3);

        qa = '{9, 0};
        qb = '{10, 0};
        for (int i = 0; i < 2; i++) begin
            step();
            chk("pause_idle_stall", s_stall, 1'b1);
            chk("pause_idle_sel", s_sel, 1'b1);
        end
        i_enable = 1'b1;
        step();
        chk("reenable_exit_stall", s_stall, 1'b1);
        step();
        chk("reenable_first_commit", s_stall, 1'b0);
        step();

        // Reset after two commits of a run
        chk("pre_rst_elem", o_elem_count, 2);
        i_rst_n = 1'b0;
        step();
        chk("midrst_stall", s_stall, 1'b1);
        chk("midrst_sel", s_sel, 1'b1);
        chk("midrst_switch", s_sw, 1'b0);
        chk("midrst_drop", s_drop, 1'b0);
        i_rst_n = 1'b1;
        chk("midrst_run_count", o_run_count, 0);
        chk("midrst_elem_count", o_elem_count, 0);
        step();
        chk("post_rst_idle_stall", s_stall, 1'b1);
        step();
        chk("post_rst_switch", s_sw, 1'b0);
        step();
        chk("run_count_after_rst", o_run_count, 1);

        // Element counter saturation
        qa = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
        qb = '{0};
        for (int i = 0; i < 10; i++) step();
        chk("run_count_final", o_run_count, 2);

        chk("log_len", log_q.size(), 28);
        for (int i = 0; i < 28; i++) begin
            if (i < log_q.size()) chk($sformatf("commit%0d", i), log_q[i], exp_log[i]);
        end
        chk("drop_count", elem_at_drop.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < elem_at_drop.size())
                chk($sformatf("elem_at_drop%0d", i), elem_at_drop[i], exp_elem[i]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
